// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite row fetcher: walks entity slots in hblank, reads ROM rows into a shadow set, serialises the active set to pixels.
// Latency: fetch N+hits+1 cycles from fetch_start to fetch_done; pixel outputs 1 cycle after h_count. No backpressure; ROM is combinational.
module sprite_line_fetcher #(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_W     = 2,
  parameter int SCALE_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_start,
  input  logic [9:0]              next_line,
  input  logic                    line_swap,
  input  logic [9:0]              h_count,
  input  logic [NUM_SLOTS-1:0]    slot_valid,
  input  logic [NUM_SLOTS*10-1:0] slot_x,
  input  logic [NUM_SLOTS*10-1:0] slot_y,
  input  logic [NUM_SLOTS*4-1:0]  slot_charc,
  input  logic [NUM_SLOTS*2-1:0]  slot_dir,
  output logic [3:0]              rom_charc,
  output logic [1:0]              rom_direction,
  output logic [2:0]              rom_index,
  input  logic [7:0]              rom_data,
  output logic                    fetch_busy,
  output logic                    fetch_done,
  output logic                    pixel_on,
  output logic [SLOT_W-1:0]       pixel_slot
);

  localparam int SPAN = 8 << SCALE_LOG2;

  typedef enum logic [1:0] {IDLE, CHECK, READ, DONE} state_t;

  state_t            state;
  logic [SLOT_W-1:0] ptr;
  logic [9:0]        line_q;

  logic [NUM_SLOTS-1:0] sh_hit;
  logic [7:0]           sh_row [NUM_SLOTS];
  logic [9:0]           sh_x   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] act_hit;
  logic [7:0]           act_row [NUM_SLOTS];
  logic [9:0]           act_x   [NUM_SLOTS];

  logic [9:0] cur_x;
  logic [9:0] cur_y;
  logic [9:0] dy;
  logic       cur_hit;
  logic       last_slot;

  assign cur_x     = slot_x[int'(ptr)*10 +: 10];
  assign cur_y     = slot_y[int'(ptr)*10 +: 10];
  // Only evaluated when line_q >= cur_y, so the subtraction never wraps.
  assign dy        = line_q - cur_y;
  assign cur_hit   = slot_valid[ptr] && (line_q >= cur_y) && (dy < 10'(SPAN));
  assign last_slot = (ptr == SLOT_W'(NUM_SLOTS-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      line_q        <= '0;
      rom_charc     <= '0;
      rom_direction <= '0;
      rom_index     <= '0;
      fetch_busy    <= 1'b0;
      fetch_done    <= 1'b0;
      sh_hit        <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sh_row[i] <= '0;
        sh_x[i]   <= '0;
      end
    end else begin
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_start) begin
            line_q     <= next_line;
            ptr        <= '0;
            fetch_busy <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (cur_hit) begin
            rom_charc     <= slot_charc[int'(ptr)*4 +: 4];
            rom_direction <= slot_dir[int'(ptr)*2 +: 2];
            rom_index     <= dy[SCALE_LOG2 +: 3];
            state         <= READ;
          end else begin
            sh_hit[ptr] <= 1'b0;
            if (last_slot) begin
              fetch_done <= 1'b1;
              state      <= DONE;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        READ: begin
          sh_row[ptr] <= rom_data;
          sh_x[ptr]   <= cur_x;
          sh_hit[ptr] <= 1'b1;
          if (last_slot) begin
            fetch_done <= 1'b1;
            state      <= DONE;
          end else begin
            ptr   <= ptr + 1'b1;
            state <= CHECK;
          end
        end
        DONE: begin
          fetch_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A swap that lands mid-fetch would expose a half-written shadow set, so the line is blanked instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_hit <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        act_row[i] <= '0;
        act_x[i]   <= '0;
      end
    end else if (line_swap) begin
      if (fetch_busy) begin
        act_hit <= '0;
      end else begin
        act_hit <= sh_hit;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          act_row[i] <= sh_row[i];
          act_x[i]   <= sh_x[i];
        end
      end
    end
  end

  logic [NUM_SLOTS-1:0] opaque;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic [9:0] col;
    assign col       = h_count - act_x[g];
    assign opaque[g] = act_hit[g] && (h_count >= act_x[g]) && (col < 10'(SPAN))
                       && !act_row[g][3'd7 - col[SCALE_LOG2 +: 3]];
  end

  logic              win;
  logic [SLOT_W-1:0] win_slot;

  always_comb begin
    win      = 1'b0;
    win_slot = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (opaque[i]) begin
        win      = 1'b1;
        win_slot = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_on   <= 1'b0;
      pixel_slot <= '0;
    end else begin
      pixel_on   <= win;
      pixel_slot <= win_slot;
    end
  end

endmodule
